// File: rtl/dbus_pkg.sv
// Shared DBus widths and master indices for the two-master data-bus arbiter.
package dbus_pkg;

    localparam int unsigned DBUS_ADDR_W = 30;
    localparam int unsigned DBUS_DATA_W = 32;
    localparam int unsigned DBUS_BE_W   = 4;

    typedef enum logic {
        M_CPU = 1'b0,
        M_DMA = 1'b1
    } master_e;

    function automatic master_e other_master(master_e m);
        return (m == M_CPU) ? M_DMA : M_CPU;
    endfunction

endpackage

// File: rtl/rr_lock_arb2.sv
// Two-way round-robin grant decision with a bounded lock that lets one master
// keep the bus for up to LOCK_MAX consecutive cycles while the other waits.
module rr_lock_arb2
    import dbus_pkg::*;
#(
    parameter int unsigned LOCK_MAX = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic [1:0] lock_i,
    output logic       gnt_valid_o,
    output master_e    gnt_idx_o
);

    localparam int unsigned CntW = $clog2(LOCK_MAX + 1);
    typedef logic [CntW-1:0] cnt_t;
    localparam cnt_t CntMax = cnt_t'(LOCK_MAX);

    master_e last_gnt_q, last_gnt_d;
    logic    locked_q, locked_d;
    cnt_t    lock_cnt_q, lock_cnt_d;
    master_e other;
    logic    hold;

    assign other = other_master(last_gnt_q);

    // The owner keeps the bus while locked, unless it has used up its quota
    // and the other master is actually waiting.
    assign hold = locked_q && req_i[last_gnt_q] &&
                  ((lock_cnt_q < CntMax) || !req_i[other]);

    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_idx_o   = M_CPU;
        if (!rst_i) begin
            if (hold) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = last_gnt_q;
            end else if (&req_i) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = other;
            end else if (req_i[M_CPU]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = M_CPU;
            end else if (req_i[M_DMA]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = M_DMA;
            end
        end
    end

    always_comb begin
        last_gnt_d = last_gnt_q;
        locked_d   = 1'b0;
        lock_cnt_d = '0;
        if (gnt_valid_o) begin
            last_gnt_d = gnt_idx_o;
            if (lock_i[gnt_idx_o]) begin
                locked_d = 1'b1;
                if (gnt_idx_o == last_gnt_q && locked_q) begin
                    lock_cnt_d = (lock_cnt_q == CntMax) ? CntMax : lock_cnt_q + 1'b1;
                end else begin
                    lock_cnt_d = cnt_t'(1);
                end
            end
        end
    end

    // Reset to DMA as last winner so the CPU wins the first contention.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_gnt_q <= M_DMA;
            locked_q   <= 1'b0;
            lock_cnt_q <= '0;
        end else begin
            last_gnt_q <= last_gnt_d;
            locked_q   <= locked_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

endmodule

// File: rtl/dbus_arbiter.sv
// Shares the DBus slaves between the CPU data port (M0) and the DMA engine (M1):
// forwards the granted request and steers one-cycle-latency read data back.
module dbus_arbiter
    import dbus_pkg::*;
#(
    parameter int unsigned LOCK_MAX   = 4,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst,

    input  logic [DBUS_ADDR_W-1:0] i_M0Addr,
    input  logic                   i_M0Re,
    input  logic                   i_M0We,
    input  logic [DBUS_BE_W-1:0]   i_M0ByteEn,
    input  logic [DBUS_DATA_W-1:0] i_M0Wd,
    input  logic                   i_M0Lock,
    output logic                   o_M0Gnt,
    output logic                   o_M0RdValid,
    output logic [DBUS_DATA_W-1:0] o_M0Rd,

    input  logic [DBUS_ADDR_W-1:0] i_M1Addr,
    input  logic                   i_M1Re,
    input  logic                   i_M1We,
    input  logic [DBUS_BE_W-1:0]   i_M1ByteEn,
    input  logic [DBUS_DATA_W-1:0] i_M1Wd,
    input  logic                   i_M1Lock,
    output logic                   o_M1Gnt,
    output logic                   o_M1RdValid,
    output logic [DBUS_DATA_W-1:0] o_M1Rd,

    output logic [DBUS_ADDR_W-1:0] o_DBusAddr,
    output logic                   o_DBusRe,
    output logic                   o_DBusWe,
    output logic [DBUS_BE_W-1:0]   o_DBusByteEn,
    output logic [DBUS_DATA_W-1:0] o_DBusWd,
    input  logic [DBUS_DATA_W-1:0] i_DBusRd
);

    if (RD_LATENCY != 1) begin : g_rd_latency_check
        $error("dbus_arbiter: only RD_LATENCY == 1 is supported");
    end

    logic    gnt_valid;
    master_e gnt_idx;
    logic    rd_pend_q, rd_pend_d;
    master_e rd_owner_q, rd_owner_d;

    rr_lock_arb2 #(
        .LOCK_MAX (LOCK_MAX)
    ) u_arb (
        .clk_i       (i_Clk),
        .rst_i       (i_Rst),
        .req_i       ({i_M1Re | i_M1We, i_M0Re | i_M0We}),
        .lock_i      ({i_M1Lock, i_M0Lock}),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx)
    );

    assign o_M0Gnt = gnt_valid && (gnt_idx == M_CPU);
    assign o_M1Gnt = gnt_valid && (gnt_idx == M_DMA);

    always_comb begin
        o_DBusAddr   = '0;
        o_DBusRe     = 1'b0;
        o_DBusWe     = 1'b0;
        o_DBusByteEn = '0;
        o_DBusWd     = '0;
        if (gnt_valid) begin
            unique case (gnt_idx)
                M_CPU: begin
                    o_DBusAddr   = i_M0Addr;
                    o_DBusRe     = i_M0Re;
                    o_DBusWe     = i_M0We;
                    o_DBusByteEn = i_M0ByteEn;
                    o_DBusWd     = i_M0Wd;
                end
                M_DMA: begin
                    o_DBusAddr   = i_M1Addr;
                    o_DBusRe     = i_M1Re;
                    o_DBusWe     = i_M1We;
                    o_DBusByteEn = i_M1ByteEn;
                    o_DBusWd     = i_M1Wd;
                end
                default: ;
            endcase
        end
    end

    // Remember who issued this cycle's read so next cycle's data goes home.
    assign rd_pend_d  = gnt_valid && o_DBusRe;
    assign rd_owner_d = rd_pend_d ? gnt_idx : rd_owner_q;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            rd_pend_q  <= 1'b0;
            rd_owner_q <= M_CPU;
        end else begin
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    // Read bus may float when no slave is selected, so gate it per master.
    assign o_M0RdValid = rd_pend_q && (rd_owner_q == M_CPU);
    assign o_M1RdValid = rd_pend_q && (rd_owner_q == M_DMA);
    assign o_M0Rd      = o_M0RdValid ? i_DBusRd : '0;
    assign o_M1Rd      = o_M1RdValid ? i_DBusRd : '0;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed bench for dbus_arbiter with a 16-word byte-writable slave and a
// per-cycle reference model of grants, forwarding and read return.
module tb_dbus_arbiter;

    localparam int LOCK_MAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  re, we, lk;
    logic [29:0] addr [2];
    logic [3:0]  be   [2];
    logic [31:0] wd   [2];

    logic        m0_gnt, m1_gnt, m0_rv, m1_rv;
    logic [31:0] m0_rd, m1_rd;
    logic [29:0] bus_addr;
    logic        bus_re, bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_wd;
    logic [31:0] dbus_rd;

    logic [31:0] mem     [16];
    logic [31:0] ref_mem [16];
    logic [31:0] rd_q;
    logic        rd_en_q = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dbus_arbiter #(
        .LOCK_MAX   (LOCK_MAX),
        .RD_LATENCY (1)
    ) dut (
        .i_Clk        (clk),
        .i_Rst        (rst),
        .i_M0Addr     (addr[0]),
        .i_M0Re       (re[0]),
        .i_M0We       (we[0]),
        .i_M0ByteEn   (be[0]),
        .i_M0Wd       (wd[0]),
        .i_M0Lock     (lk[0]),
        .o_M0Gnt      (m0_gnt),
        .o_M0RdValid  (m0_rv),
        .o_M0Rd       (m0_rd),
        .i_M1Addr     (addr[1]),
        .i_M1Re       (re[1]),
        .i_M1We       (we[1]),
        .i_M1ByteEn   (be[1]),
        .i_M1Wd       (wd[1]),
        .i_M1Lock     (lk[1]),
        .o_M1Gnt      (m1_gnt),
        .o_M1RdValid  (m1_rv),
        .o_M1Rd       (m1_rd),
        .o_DBusAddr   (bus_addr),
        .o_DBusRe     (bus_re),
        .o_DBusWe     (bus_we),
        .o_DBusByteEn (bus_be),
        .o_DBusWd     (bus_wd),
        .i_DBusRd     (dbus_rd)
    );

    // Slave: registered read (old data on simultaneous write), byte-enabled write.
    assign dbus_rd = rd_en_q ? rd_q : 32'bz;
    always @(posedge clk) begin
        rd_en_q <= bus_re;
        if (bus_re) rd_q <= mem[bus_addr[3:0]];
        if (bus_we) begin
            for (int b = 0; b < 4; b++) begin
                if (bus_be[b]) mem[bus_addr[3:0]][8*b +: 8] <= bus_wd[8*b +: 8];
            end
        end
    end

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: last winner, lock streak, pending read.
    int          m_last   = 1;
    bit          m_locked = 1'b0;
    int          m_streak = 0;
    bit          m_pend   = 1'b0;
    int          m_who    = 0;
    logic [31:0] m_data   = '0;

    always @(negedge clk) begin : cmp
        bit   [1:0]  req_m;
        bit          gv;
        int          g;
        logic [67:0] exp_bus;
        logic [1:0]  exp_gnt, exp_rv;
        if (rst) begin
            chk("rst_gnt", {m1_gnt, m0_gnt}, 0);
            chk("rst_rv", {m1_rv, m0_rv}, 0);
            chk("rst_rd", {m1_rd, m0_rd}, 0);
            chk("rst_bus", {bus_addr, bus_re, bus_we, bus_be, bus_wd}, 0);
            m_last = 1; m_locked = 0; m_streak = 0; m_pend = 0;
        end else begin
            req_m = re | we;
            gv = 0; g = 0;
            if (m_locked && req_m[m_last] && (m_streak < LOCK_MAX || !req_m[1-m_last])) begin
                gv = 1; g = m_last;
            end else if (req_m == 2'b11) begin
                gv = 1; g = 1 - m_last;
            end else if (req_m[0]) begin
                gv = 1; g = 0;
            end else if (req_m[1]) begin
                gv = 1; g = 1;
            end
            exp_gnt = gv ? (2'b01 << g) : 2'b00;
            exp_bus = gv ? {addr[g], re[g], we[g], be[g], wd[g]} : 68'd0;
            exp_rv  = m_pend ? (2'b01 << m_who) : 2'b00;
            chk("gnt", {m1_gnt, m0_gnt}, exp_gnt);
            chk("bus", {bus_addr, bus_re, bus_we, bus_be, bus_wd}, exp_bus);
            chk("rdvalid", {m1_rv, m0_rv}, exp_rv);
            chk("rd0", m0_rd, exp_rv[0] ? m_data : 32'd0);
            chk("rd1", m1_rd, exp_rv[1] ? m_data : 32'd0);
            if (gv) begin
                if (lk[g]) begin
                    m_streak = (g == m_last && m_locked) ?
                               ((m_streak < LOCK_MAX) ? m_streak + 1 : LOCK_MAX) : 1;
                end else begin
                    m_streak = 0;
                end
                m_locked = lk[g];
                m_last   = g;
                m_pend   = re[g];
                if (re[g]) begin
                    m_who  = g;
                    m_data = ref_mem[addr[g][3:0]];
                end
                if (we[g]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (be[g][b]) ref_mem[addr[g][3:0]][8*b +: 8] = wd[g][8*b +: 8];
                    end
                end
            end else begin
                m_locked = 0; m_streak = 0; m_pend = 0;
            end
        end
    end

    task automatic idle();
        re = '0; we = '0; lk = '0;
        for (int m = 0; m < 2; m++) begin
            addr[m] = '0; be[m] = '0; wd[m] = '0;
        end
    endtask

    task automatic to_check();
        @(negedge clk);
        #1;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[0] = 32'h0000_0003;
        mem[1] = 32'h1111_1111;
        mem[2] = 32'h2222_2222;
        for (int i = 0; i < 16; i++) ref_mem[i] = mem[i];
        idle();
        rst = 1'b1;
        re  = 2'b11;
        next();
        to_check();
        chk("rst_no_gnt", {m1_gnt, m0_gnt}, 0);
        next();

        // Contention straight after reset: M0 first, then alternate.
        rst = 1'b0;
        re = 2'b11; addr[0] = 30'd1; addr[1] = 30'd2;
        for (int i = 0; i < 4; i++) begin
            to_check();
            chk("cont_gnt", {m1_gnt, m0_gnt}, (i % 2 == 0) ? 2'b01 : 2'b10);
            if (i > 0) begin
                chk("cont_rv", {m1_rv, m0_rv}, (i % 2 == 1) ? 2'b01 : 2'b10);
                chk("cont_rd", {m1_rd, m0_rd},
                    (i % 2 == 1) ? {32'd0, 32'h1111_1111} : {32'h2222_2222, 32'd0});
            end
            next();
        end
        idle();
        to_check();
        chk("cont_last_rv", {m1_rv, m0_rv}, 2'b10);
        chk("cont_last_rd", m1_rd, 32'h2222_2222);
        next();

        // Solo read of word 0.
        re[0] = 1'b1; addr[0] = 30'h000;
        to_check();
        chk("solo_gnt", {m1_gnt, m0_gnt}, 2'b01);
        chk("solo_bus_re", bus_re, 1'b1);
        next();
        idle();
        to_check();
        chk("solo_rv", {m1_rv, m0_rv}, 2'b01);
        chk("solo_rd", m0_rd, 32'h0000_0003);
        next();

        // Byte write by M1, then M0 reads it back.
        we[1] = 1'b1; addr[1] = 30'h005; be[1] = 4'b0010; wd[1] = 32'hAABB_CCDD;
        to_check();
        chk("bw_bus", {bus_addr, bus_re, bus_we, bus_be, bus_wd},
            {30'h005, 1'b0, 1'b1, 4'b0010, 32'hAABB_CCDD});
        next();
        idle();
        re[0] = 1'b1; addr[0] = 30'h005;
        to_check();
        chk("bw_no_rv", {m1_rv, m0_rv}, 2'b00);
        next();
        idle();
        to_check();
        chk("bw_rd", m0_rd, 32'h0000_CC00);
        next();

        // M1 locks against a continuously requesting M0.
        re = 2'b11; lk[1] = 1'b1; addr[0] = 30'd1; addr[1] = 30'd2;
        for (int i = 0; i < 5; i++) begin
            to_check();
            chk("lock_gnt", {m1_gnt, m0_gnt}, (i < 4) ? 2'b10 : 2'b01);
            next();
        end
        idle();

        // Lock with M0 idle holds indefinitely; counter must saturate.
        re[1] = 1'b1; lk[1] = 1'b1;
        for (int i = 0; i < 9; i++) begin
            to_check();
            chk("sat_hold", {m1_gnt, m0_gnt}, 2'b10);
            next();
        end
        re[0] = 1'b1;
        to_check();
        chk("sat_yield", {m1_gnt, m0_gnt}, 2'b01);
        next();
        idle();

        // Lock release: M1 drops its request, M0 takes the bus that cycle.
        re[1] = 1'b1; lk[1] = 1'b1;
        next();
        next();
        re = 2'b01; lk = 2'b00;
        to_check();
        chk("rel_gnt", {m1_gnt, m0_gnt}, 2'b01);
        next();
        re = 2'b11;
        to_check();
        chk("rel_rr", {m1_gnt, m0_gnt}, 2'b10);
        next();
        idle();

        // Async reset between a granted read and its return.
        re[0] = 1'b1; addr[0] = 30'h000;
        to_check();
        chk("ar_gnt", {m1_gnt, m0_gnt}, 2'b01);
        next();
        idle();
        re = 2'b11;
        rst = 1'b1;
        #1;
        chk("ar_rv", {m1_rv, m0_rv}, 2'b00);
        chk("ar_rd", {m1_rd, m0_rd}, 0);
        chk("ar_gnt0", {m1_gnt, m0_gnt}, 2'b00);
        chk("ar_bus", {bus_addr, bus_re, bus_we, bus_be, bus_wd}, 0);
        next();
        next();
        rst = 1'b0;
        to_check();
        chk("ar_first", {m1_gnt, m0_gnt}, 2'b01);
        next();
        idle();
        to_check();
        next();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
